ex_result_stage: RTL and testbench
==================================

Name: ex_result_stage

Overview:
- Execute-to-writeback pipeline stage that sits directly downstream of the 16-bit ALU.
- Registers the ALU result and destination info in a one-entry valid/ready pipeline register.
- Owns the architectural status register {V,N,Z}: it is loaded from the ALU flag vector on status-writing instructions.
- Evaluates branch conditions against the stored status and counts retired instructions.

Parameters:
DATA_W, 16, datapath width (ALU result width)
RD_W, 3, destination register index width
CNT_W, 16, retired-instruction counter width

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream (ALU stage) presents an instruction
in_ready  output  1  stage can accept this cycle
alu_out  input  DATA_W  ALU result
alu_flags  input  3  ALU flags: [2]=overflow V, [1]=negative N, [0]=zero Z
in_rd  input  RD_W  destination register index
in_wr_reg  input  1  instruction writes the register file
in_ld_status  input  1  instruction updates the status register (e.g. CMP)
in_is_branch  input  1  instruction is a conditional branch
in_cond  input  3  branch condition code
flush  input  1  kill the held entry and the incoming instruction
out_valid  output  1  entry valid toward writeback
out_ready  input  1  writeback accepts the entry
out_c  output  DATA_W  registered result
out_rd  output  RD_W  registered destination
out_wr_reg  output  1  registered write enable; forced to 0 when out_valid=0
branch_taken  output  1  registered; meaningful only while out_valid=1
status  output  3  architectural {V,N,Z}
retired  output  CNT_W  count of output handshakes

Behaviour:
- Reset, checked at the clk edge with reset=1, clears all of the following to 0: out_valid, out_c, out_rd, out_wr_reg, branch_taken, status and retired. Reset overrides flush and every handshake in that cycle.
- Ready rule: in_ready = ~out_valid | out_ready. This is combinational and does not depend on in_valid.
- Accept: when in_valid & in_ready & ~flush, the entry loads at the next edge, with one-cycle latency:
  - out_c <= alu_out, out_rd <= in_rd, out_wr_reg <= in_wr_reg, out_valid <= 1.
- Hold: when out_valid & ~out_ready, all out_* and branch_taken stay stable. Upstream data is ignored.
- Drain: when out_valid & out_ready and there is no accept, out_valid <= 0 at the next edge.
- Back-to-back: an output handshake and an accept in the same cycle replace the entry. This gives full throughput, one instruction per cycle, with no bubble.
- Status register: on an accept with in_ld_status=1, status <= alu_flags. Otherwise status holds.
- Branch evaluation:
  - Evaluated at accept time against the status value before that cycle's update.
  - branch_taken <= in_is_branch & cond_true.
  - A status-writing instruction never evaluates its own flags; a following branch sees them.
- Condition codes, with cond_true defined as:
  - 000: always (1).
  - 001: EQ, Z.
  - 010: NE, ~Z.
  - 011: LT, N^V.
  - 100: LE, (N^V)|Z.
  - 101, 110, 111: never (0).
- Flush (flush=1):
  - out_valid <= 0, out_wr_reg <= 0, branch_taken <= 0.
  - The incoming instruction is dropped and status is not updated.
  - retired does not increment, even if out_ready=1 in that cycle.
  - Flush wins over a simultaneous accept.
- Retired counter: increments by 1 on each output handshake (out_valid & out_ready & ~flush) and wraps from 2^CNT_W-1 to 0.
- No X propagation: outputs are well-defined after reset regardless of input X while in_valid=0.

Test Plan:
1. Reset: assert reset for 2 cycles with in_valid=1 -> out_valid=0, status=000, retired=0, in_ready=1.
2. Single transfer: alu_out=16'h1234, in_rd=3, in_wr_reg=1, out_ready=1 -> next cycle out_valid=1, out_c=16'h1234, out_rd=3; cycle after that out_valid=0 and retired=1.
3. Backpressure: hold out_ready=0 for 3 cycles while in_valid=1 with changing alu_out -> in_ready=0 and out_c stays at its first value; on release, each of the next 3 streamed entries appears on consecutive cycles.
4. CMP then branch:
   - Accept CMP with in_ld_status=1 and alu_flags=3'b001 -> status=001.
   - Next branch with in_cond=001 -> branch_taken=1.
   - A branch with in_cond=010 instead -> branch_taken=0.
   - A branch issued in the same accept as a ld_status instruction uses the old status.
5. LT/overflow case: status loaded with V=1, N=0 (3'b100), then a branch with in_cond=011 -> branch_taken=1. With in_cond=100 -> 1. With in_cond=111 -> 0.
6. Flush and wrap:
   - flush=1 together with in_valid=1 and ld_status=1 -> out_valid=0 next cycle, status unchanged, retired unchanged.
   - Preload retired to 16'hFFFF via 65535 handshakes (or force), then one handshake -> retired=0.

Source files
------------

// File: rtl/ex_result_stage.sv
// ex_result_stage: execute-to-writeback pipeline register behind the 16-bit ALU.
//
// Holds one instruction result in a valid/ready register slice, owns the
// architectural {V,N,Z} status register, evaluates branch conditions against
// it and counts retired instructions (output handshakes).
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready     upstream handshake (ALU stage)
//   alu_out, alu_flags      ALU result and flags {V,N,Z}
//   in_rd, in_wr_reg        destination index and register-file write enable
//   in_ld_status            instruction loads the status register
//   in_is_branch, in_cond   conditional branch and its condition code
//   flush                   kill held entry and incoming instruction
//   out_valid / out_ready   downstream handshake (writeback)
//   out_c, out_rd, out_wr_reg, branch_taken   registered entry fields
//   status                  architectural {V,N,Z}
//   retired                 wrapping count of output handshakes
module ex_result_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_W   = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [2:0]        alu_flags,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wr_reg,
  input  logic              in_ld_status,
  input  logic              in_is_branch,
  input  logic [2:0]        in_cond,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_c,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wr_reg,
  output logic              branch_taken,
  output logic [2:0]        status,
  output logic [CNT_W-1:0]  retired
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] c_q, c_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              taken_q, taken_d;
  logic [2:0]        status_q, status_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic accept;
  logic out_hs;
  logic cond_true;

  assign in_ready = ~valid_q | out_ready;
  assign accept   = in_valid & in_ready & ~flush;
  assign out_hs   = valid_q & out_ready & ~flush;

  // Branches see the status held before this cycle's update, so a CMP never
  // evaluates its own flags.
  always_comb begin
    cond_true = 1'b0;
    case (in_cond)
      3'b000:  cond_true = 1'b1;
      3'b001:  cond_true = status_q[0];
      3'b010:  cond_true = ~status_q[0];
      3'b011:  cond_true = status_q[1] ^ status_q[2];
      3'b100:  cond_true = (status_q[1] ^ status_q[2]) | status_q[0];
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    valid_d   = valid_q;
    c_d       = c_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    taken_d   = taken_q;
    status_d  = status_q;
    retired_d = retired_q;

    if (flush) begin
      valid_d = 1'b0;
      wr_d    = 1'b0;
      taken_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      c_d     = alu_out;
      rd_d    = in_rd;
      wr_d    = in_wr_reg;
      taken_d = in_is_branch & cond_true;
      if (in_ld_status) begin
        status_d = alu_flags;
      end
    end else if (out_hs) begin
      // Drain: keep the write enable low whenever the entry is empty.
      valid_d = 1'b0;
      wr_d    = 1'b0;
    end

    if (out_hs) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      c_q       <= '0;
      rd_q      <= '0;
      wr_q      <= 1'b0;
      taken_q   <= 1'b0;
      status_q  <= 3'b000;
      retired_q <= '0;
    end else begin
      valid_q   <= valid_d;
      c_q       <= c_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      taken_q   <= taken_d;
      status_q  <= status_d;
      retired_q <= retired_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_c        = c_q;
  assign out_rd       = rd_q;
  assign out_wr_reg   = wr_q;
  assign branch_taken = taken_q;
  assign status       = status_q;
  assign retired      = retired_q;

endmodule

// File: tb/tb_ex_result_stage.sv
module tb_ex_result_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] alu_out;
  logic [2:0]  alu_flags;
  logic [2:0]  in_rd;
  logic        in_wr_reg;
  logic        in_ld_status;
  logic        in_is_branch;
  logic [2:0]  in_cond;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_c;
  logic [2:0]  out_rd;
  logic        out_wr_reg;
  logic        branch_taken;
  logic [2:0]  status;
  logic [15:0] retired;

  ex_result_stage #(
    .DATA_W(16),
    .RD_W  (3),
    .CNT_W (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_out     (alu_out),
    .alu_flags   (alu_flags),
    .in_rd       (in_rd),
    .in_wr_reg   (in_wr_reg),
    .in_ld_status(in_ld_status),
    .in_is_branch(in_is_branch),
    .in_cond     (in_cond),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_c       (out_c),
    .out_rd      (out_rd),
    .out_wr_reg  (out_wr_reg),
    .branch_taken(branch_taken),
    .status      (status),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] c;
    logic [2:0]  rd;
    logic        wr;
    logic        br;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  logic [2:0] model_status = 3'b000;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  function automatic logic cond_model(input logic [2:0] cc, input logic [2:0] s);
    logic v, n, z;
    v = s[2];
    n = s[1];
    z = s[0];
    case (cc)
      3'd0:    return 1'b1;
      3'd1:    return z;
      3'd2:    return !z;
      3'd3:    return n ^ v;
      3'd4:    return (n ^ v) | z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction, waits (bounded) until it is accepted and
  // records the expected output entry in the scoreboard.
  task automatic issue(input logic [2:0] rd, input logic [15:0] c, input logic wr,
                       input logic ld, input logic [2:0] fl, input logic br,
                       input logic [2:0] cond);
    int   n;
    exp_t e;
    in_valid     = 1'b1;
    alu_out      = c;
    in_rd        = rd;
    in_wr_reg    = wr;
    in_ld_status = ld;
    alu_flags    = fl;
    in_is_branch = br;
    in_cond      = cond;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_vec++;
      n_fail++;
      $display("FAIL issue_timeout: in_ready got 0, expected 1 within 20 cycles");
      in_valid = 1'b0;
      return;
    end
    e.c  = c;
    e.rd = rd;
    e.wr = wr;
    e.br = br & cond_model(cond, model_status);
    exp_q.push_back(e);
    if (ld) model_status = fl;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) tick();
  endtask

  // Scoreboard monitor: every output handshake pops one expected entry.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL entry: got unexpected entry c=%0h rd=%0h, expected none", out_c, out_rd);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("entry", {11'd0, out_c, out_rd, out_wr_reg, branch_taken},
              {11'd0, e.c, e.rd, e.wr, e.br});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    in_valid     = 1'b1;
    alu_out      = 16'hDEAD;
    alu_flags    = 3'b111;
    in_rd        = 3'd5;
    in_wr_reg    = 1'b1;
    in_ld_status = 1'b1;
    in_is_branch = 1'b1;
    in_cond      = 3'b000;
    flush        = 1'b0;
    out_ready    = 1'b0;

    // 1. Reset with in_valid asserted
    repeat (2) tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_status", {29'd0, status}, 32'd0);
    check("rst_retired", {16'd0, retired}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_c", {16'd0, out_c}, 32'd0);
    reset    = 1'b0;
    in_valid = 1'b0;
    tick();

    // 2. Single transfer
    out_ready = 1'b1;
    issue(3'd3, 16'h1234, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000);
    check("single_valid", {31'd0, out_valid}, 32'd1);
    check("single_c", {16'd0, out_c}, 32'h1234);
    tick();
    check("single_drained", {31'd0, out_valid}, 32'd0);
    check("single_wr_low", {31'd0, out_wr_reg}, 32'd0);
    check("single_retired", {16'd0, retired}, 32'd1);

    // 3. Backpressure then streaming
    out_ready = 1'b0;
    issue(3'd1, 16'hAAAA, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_out = 16'hB000 + 16'(i);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_hold_c", {16'd0, out_c}, 32'hAAAA);
      tick();
    end
    out_ready = 1'b1;
    issue(3'd2, 16'hB003, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000);
    check("stream_b", {15'd0, out_valid, out_c}, {15'd0, 1'b1, 16'hB003});
    issue(3'd4, 16'hC0DE, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000);
    check("stream_c", {15'd0, out_valid, out_c}, {15'd0, 1'b1, 16'hC0DE});
    issue(3'd7, 16'hD00D, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000);
    check("stream_d", {15'd0, out_valid, out_c}, {15'd0, 1'b1, 16'hD00D});
    tick();
    check("stream_retired", {16'd0, retired}, 32'd5);

    // 4. CMP then branches
    issue(3'd0, 16'h0000, 1'b0, 1'b1, 3'b001, 1'b0, 3'b000);
    check("cmp_status", {29'd0, status}, 32'b001);
    issue(3'd0, 16'h0010, 1'b0, 1'b0, 3'b000, 1'b1, 3'b001);
    check("beq_taken", {31'd0, branch_taken}, 32'd1);
    issue(3'd0, 16'h0020, 1'b0, 1'b0, 3'b000, 1'b1, 3'b010);
    check("bne_not_taken", {31'd0, branch_taken}, 32'd0);
    issue(3'd0, 16'h0030, 1'b0, 1'b1, 3'b000, 1'b1, 3'b001);
    check("same_cycle_old_status", {31'd0, branch_taken}, 32'd1);
    check("same_cycle_new_status", {29'd0, status}, 32'b000);
    tick();
    check("cmp_retired", {16'd0, retired}, 32'd9);

    // 5. LT / LE with overflow
    issue(3'd0, 16'h0040, 1'b0, 1'b1, 3'b100, 1'b0, 3'b000);
    issue(3'd0, 16'h0050, 1'b0, 1'b0, 3'b000, 1'b1, 3'b011);
    check("blt_taken", {31'd0, branch_taken}, 32'd1);
    issue(3'd0, 16'h0060, 1'b0, 1'b0, 3'b000, 1'b1, 3'b100);
    check("ble_taken", {31'd0, branch_taken}, 32'd1);
    issue(3'd0, 16'h0070, 1'b0, 1'b0, 3'b000, 1'b1, 3'b111);
    check("bnever", {31'd0, branch_taken}, 32'd0);
    drain();
    check("lt_retired", {16'd0, retired}, 32'd13);

    // 6a. Flush kills held entry and incoming ld_status instruction
    out_ready = 1'b0;
    issue(3'd6, 16'hF00F, 1'b1, 1'b0, 3'b000, 1'b1, 3'b000);
    in_valid     = 1'b1;
    in_ld_status = 1'b1;
    alu_flags    = 3'b011;
    flush        = 1'b1;
    out_ready    = 1'b1;
    exp_q.delete();
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_wr", {31'd0, out_wr_reg}, 32'd0);
    check("flush_taken", {31'd0, branch_taken}, 32'd0);
    check("flush_status", {29'd0, status}, 32'b100);
    check("flush_retired", {16'd0, retired}, 32'd13);
    tick();
    check("flush_idle", {30'd0, out_valid, in_ready}, 32'b01);

    // 6b. Counter wrap
    for (int i = 0; i < 65522; i++) begin
      issue(3'(i), 16'(i), 1'b1, 1'b0, 3'b000, 1'b0, 3'b000);
    end
    tick();
    check("retired_max", {16'd0, retired}, 32'hFFFF);
    issue(3'd5, 16'h5A5A, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000);
    tick();
    check("retired_wrap", {16'd0, retired}, 32'd0);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
